// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encodings and the default text base shared with the CPU's reset PC.
package imem_boot_loader_pkg;

   typedef enum logic [2:0] {
      S_LEN_HI = 3'd0,
      S_LEN_LO = 3'd1,
      S_DATA   = 3'd2,
      S_CKSUM  = 3'd3,
      S_DONE   = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0000_3000;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; word_valid is high
// (combinationally) on the cycle the 4th byte of a word is accepted.
module imem_boot_loader_byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  in_byte,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  idx;
   logic [23:0] shreg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx   <= '0;
         shreg <= '0;
      end else if (en) begin
         idx   <= idx + 2'd1;
         shreg <= {shreg[15:0], in_byte};
      end
   end

   // The first three bytes live in shreg; the 4th completes the word directly.
   assign word_valid = en && (idx == 2'd3);
   assign word       = {shreg, in_byte};

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader for the instruction ROM; holds the CPU in reset
// until the image is written. Define BOOT_CHECKSUM_EN for a trailing XOR byte.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter logic [31:0] TEXT_BASE = DEFAULT_TEXT_BASE,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err,
   output logic [15:0]       word_count,
   output logic [31:0]       boot_pc
);

   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   state_t      state, next_state;
   logic [7:0]  len_hi;
   logic [15:0] len;
   logic [15:0] frame_len;
   logic        accept;
   logic        pack_en;
   logic        word_valid;
   logic [31:0] word;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]  cksum;
`endif

   assign accept    = in_valid && in_ready;
   assign pack_en   = accept && (state == S_DATA);
   assign frame_len = {len_hi, in_byte};
   assign boot_pc   = TEXT_BASE;

   imem_boot_loader_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .en         (pack_en),
      .in_byte    (in_byte),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= S_LEN_HI;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_LEN_HI: if (accept) next_state = S_LEN_LO;
         S_LEN_LO: begin
            if (accept) begin
               if (frame_len == 16'd0)                next_state = S_DONE;
               else if ({1'b0, frame_len} > MAX_LEN)  next_state = S_ERR;
               else                                   next_state = S_DATA;
            end
         end
         S_DATA: begin
            if (word_valid && (16'(word_count + 16'd1) == len)) begin
`ifdef BOOT_CHECKSUM_EN
               next_state = S_CKSUM;
`else
               next_state = S_DONE;
`endif
            end
         end
`ifdef BOOT_CHECKSUM_EN
         S_CKSUM: if (accept) next_state = (in_byte == cksum) ? S_DONE : S_ERR;
`endif
         S_DONE:  next_state = S_DONE;
         S_ERR:   next_state = S_ERR;
         default: next_state = S_ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         len_hi     <= '0;
         len        <= '0;
         word_count <= '0;
         in_ready   <= 1'b0;
         im_we      <= 1'b0;
         im_addr    <= '0;
         im_wdata   <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         cpu_rst    <= 1'b1;
      end else begin
         in_ready <= (next_state == S_LEN_HI) || (next_state == S_LEN_LO) ||
                     (next_state == S_DATA)   || (next_state == S_CKSUM);
         im_we    <= word_valid;
         if (accept && (state == S_LEN_HI)) len_hi <= in_byte;
         if (accept && (state == S_LEN_LO)) len    <= frame_len;
         if (word_valid) begin
            im_addr    <= word_count[ADDR_W-1:0];
            im_wdata   <= word;
            word_count <= word_count + 16'd1;
         end
         done    <= (next_state == S_DONE);
         err     <= (next_state == S_ERR);
         // Released from the registered state so the CPU leaves reset one cycle after done.
         cpu_rst <= (state != S_DONE);
      end
   end

`ifdef BOOT_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst)         cksum <= '0;
      else if (pack_en) cksum <= cksum ^ in_byte;
   end
`endif

endmodule
